alu_seq: RTL and testbench

- Parametrised N-bit sequential ALU with valid/ready handshakes on input and output.
- Adds a multi-cycle shift-add multiply and an accumulator register to the basic add/sub/and/or set.
- Sits between the switch/button front end and the HEX/LED display logic of board tops.
- Used as the compute core for stepped calculator labs.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu.sv | 25 ++
 rtl/mul_shift_add.sv | 59 +++++
 rtl/alu_seq.sv | 140 ++++++++++++++
 tb/tb_alu_seq.sv | 190 +++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and control-state encodings.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    AND  = 3'd2,
    OR   = 3'd3,
    MUL  = 3'd4,
    ACC  = 3'd5,
    RSV6 = 3'd6,
    RSV7 = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between the front end and alu_seq.
interface alu_seq_if #(parameter int N = 4);
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_a;
  logic [N-1:0] i_b;
  logic [2:0]   i_op;
  logic         i_acc_clr;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_result;
  logic         o_carry_out;
  logic         o_zero;
  logic [N-1:0] o_acc;
  logic         o_busy;

  modport slave (
    input  i_valid, i_a, i_b, i_op, i_acc_clr, i_ready,
    output o_ready, o_valid, o_result, o_carry_out, o_zero, o_acc, o_busy
  );

  modport master (
    output i_valid, i_a, i_b, i_op, i_acc_clr, i_ready,
    input  o_ready, o_valid, o_result, o_carry_out, o_zero, o_acc, o_busy
  );
endinterface

// File: rtl/alu.sv
// Combinational N-bit add/sub/and/or unit; carry is bit N of the adder (no-borrow on sub).
module alu #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [1:0]   i_ctrl,
  output logic [N-1:0] o_y,
  output logic         o_carry
);
  logic [N-1:0] b_x;
  logic [N:0]   sum;

  always_comb begin
    b_x = i_ctrl[0] ? ~i_b : i_b;
    sum = {1'b0, i_a} + {1'b0, b_x} + {{N{1'b0}}, i_ctrl[0]};
    o_y     = sum[N-1:0];
    o_carry = sum[N];
    unique case (i_ctrl)
      2'b10: begin o_y = i_a & i_b; o_carry = 1'b0; end
      2'b11: begin o_y = i_a | i_b; o_carry = 1'b0; end
      default: ;
    endcase
  end
endmodule

// File: rtl/mul_shift_add.sv
// Right-shifting shift-add multiplier: loads on i_start, then one step per cycle for N cycles.
module mul_shift_add #(
  parameter int N = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_done,
  output logic [2*N-1:0] o_prod
);
  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] prod_q, prod_d, step_prod;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplr_q, mplr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   addend;
  logic [N:0]     hi_sum;

  always_comb begin
    addend    = mplr_q[0] ? mcand_q : {N{1'b0}};
    hi_sum    = {1'b0, prod_q[2*N-1:N]} + {1'b0, addend};
    step_prod = {hi_sum, prod_q[N-1:1]};
    prod_d  = prod_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    if (i_start) begin
      prod_d  = '0;
      mcand_d = i_a;
      mplr_d  = i_b;
      cnt_d   = CW'(N);
    end else if (cnt_q != '0) begin
      prod_d = step_prod;
      mplr_d = mplr_q >> 1;
      cnt_d  = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prod_q  <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Done flags the cycle whose edge performs the final step; o_prod is that step's result.
  assign o_done = (cnt_q == CW'(1));
  assign o_prod = step_prod;
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic/acc, N-cycle multiply, held result until accepted.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  alu_seq_if.slave   bus
);
  alu_state_e   state_q, state_d;
  logic         ready_q, ready_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic [N-1:0] result_q, result_d;
  logic         carry_q, carry_d;
  logic         zero_q, zero_d;
  logic [N-1:0] acc_q, acc_d;

  alu_op_e        op_in;
  logic           accept;
  logic [N-1:0]   alu_b, alu_y;
  logic [1:0]     alu_ctrl;
  logic           alu_c;
  logic           mul_start, mul_done;
  logic [2*N-1:0] mul_prod;
  logic [N-1:0]   sel_res;
  logic           sel_cy;

  assign op_in     = alu_op_e'(bus.i_op);
  assign accept    = ready_q & bus.i_valid;
  assign mul_start = accept && (op_in == MUL);
  // ACC reuses the adder with the accumulator snapshot taken at accept as operand B.
  assign alu_ctrl  = (op_in == ACC) ? 2'b00 : bus.i_op[1:0];
  assign alu_b     = (op_in == ACC) ? acc_q : bus.i_b;

  alu #(.N(N)) u_alu (
    .i_a    (bus.i_a),
    .i_b    (alu_b),
    .i_ctrl (alu_ctrl),
    .o_y    (alu_y),
    .o_carry(alu_c)
  );

  mul_shift_add #(.N(N)) u_mul (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(mul_start),
    .i_a    (bus.i_a),
    .i_b    (bus.i_b),
    .o_done (mul_done),
    .o_prod (mul_prod)
  );

  always_comb begin
    sel_res = '0;
    sel_cy  = 1'b0;
    unique case (op_in)
      ADD, SUB, AND, OR, ACC: begin sel_res = alu_y; sel_cy = alu_c; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    acc_d    = acc_q;
    unique case (state_q)
      IDLE: if (accept) begin
        ready_d = 1'b0;
        if (op_in == MUL) begin
          state_d = MULT;
          busy_d  = 1'b1;
        end else begin
          state_d  = DONE;
          valid_d  = 1'b1;
          result_d = sel_res;
          carry_d  = sel_cy;
          zero_d   = (sel_res == '0);
        end
      end
      MULT: if (mul_done) begin
        state_d  = DONE;
        busy_d   = 1'b0;
        valid_d  = 1'b1;
        result_d = mul_prod[N-1:0];
        carry_d  = |mul_prod[2*N-1:N];
        zero_d   = (mul_prod[N-1:0] == '0);
      end
      DONE: if (bus.i_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
        acc_d   = result_q;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
    if (bus.i_acc_clr) acc_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      acc_q    <= acc_d;
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_result    = result_q;
  assign bus.o_carry_out = carry_q;
  assign bus.o_zero      = zero_q;
  assign bus.o_acc       = acc_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=4) with a cycle-level behavioural model and per-cycle compare.
module tb_alu_seq;
  localparam int N = 4;
  localparam int MASK = (1 << N) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  alu_seq_if #(.N(N)) bus ();

  alu_seq #(.N(N)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference straight from the opcode table.
  function automatic int model_op(input int op, input int a, input int b, input int acc,
                                  output int c);
    int s;
    s = 0; c = 0;
    case (op)
      0: begin s = a + b;   c = (s > MASK) ? 1 : 0; end
      1: begin s = a - b;   c = (a >= b) ? 1 : 0; end
      2: s = a & b;
      3: s = a | b;
      4: begin s = a * b;   c = (s > MASK) ? 1 : 0; end
      5: begin s = acc + a; c = (s > MASK) ? 1 : 0; end
      default: s = 0;
    endcase
    return s & MASK;
  endfunction

  // Model state: one op in flight, cycles since accept, latency, shown result, accumulator.
  bit in_flight = 0;
  int since = 0, lat_m = 1, m_op = 0;
  int p_res = 0, p_carry = 0, exp_res = 0, exp_carry = 0, m_acc = 0;
  bit was_idle, hs;
  int acc_old;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight = 0; since = 0; m_acc = 0; exp_res = 0; exp_carry = 0;
    end else begin
      was_idle = !in_flight;
      acc_old  = m_acc;
      hs       = 0;
      if (in_flight) begin
        if (since >= lat_m && bus.i_ready) begin in_flight = 0; hs = 1; end
        since++;
      end
      if (bus.i_acc_clr) m_acc = 0;
      else if (hs) m_acc = exp_res;
      if (was_idle && bus.i_valid) begin
        m_op  = int'(bus.i_op);
        p_res = model_op(m_op, int'(bus.i_a), int'(bus.i_b), acc_old, p_carry);
        lat_m = (m_op == 4) ? N + 1 : 1;
        since = 1;
        in_flight = 1;
      end
      if (in_flight && since == lat_m) begin exp_res = p_res; exp_carry = p_carry; end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_ready", bus.o_ready, 1);
      chk("rst_busy",  bus.o_busy, 0);
      chk("rst_result", bus.o_result, 0);
      chk("rst_carry", bus.o_carry_out, 0);
      chk("rst_zero",  bus.o_zero, 1);
      chk("rst_acc",   bus.o_acc, 0);
    end else begin
      chk("cyc_valid",  bus.o_valid, (in_flight && since >= lat_m) ? 1 : 0);
      chk("cyc_ready",  bus.o_ready, in_flight ? 0 : 1);
      chk("cyc_busy",   bus.o_busy, (in_flight && m_op == 4 && since <= N) ? 1 : 0);
      chk("cyc_result", bus.o_result, exp_res);
      chk("cyc_carry",  bus.o_carry_out, exp_carry);
      chk("cyc_zero",   bus.o_zero, (exp_res == 0) ? 1 : 0);
      chk("cyc_acc",    bus.o_acc, m_acc);
    end
  end

  task automatic run_op(input int op, input int a, input int b, input int hold, input bit pulse,
                        input bit clr, input int er, input int ec, input int elat);
    int lat, busy_n;
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_op = 3'(op); bus.i_a = 4'(a); bus.i_b = 4'(b);
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_op = 3'd6; bus.i_a = ~4'(a); bus.i_b = ~4'(b);
    lat = 1; busy_n = 0;
    while (!bus.o_valid && lat < 30) begin
      if (bus.o_busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, elat);
    chk("busy_cycles", busy_n, (op == 4) ? N : 0);
    chk("result", bus.o_result, er);
    chk("carry", bus.o_carry_out, ec);
    chk("zero", bus.o_zero, (er == 0) ? 1 : 0);
    for (int i = 0; i < hold; i++) begin
      bus.i_valid = (pulse && i == 0);
      bus.i_op = 3'd0; bus.i_a = 4'hF; bus.i_b = 4'hF;
      @(negedge clk);
      chk("hold_valid", bus.o_valid, 1);
      chk("hold_ready", bus.o_ready, 0);
      chk("hold_result", bus.o_result, er);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1; bus.i_acc_clr = clr;
    @(negedge clk);
    bus.i_ready = 1'b0; bus.i_acc_clr = 1'b0;
    chk("back_idle", bus.o_ready, 1);
  endtask

  initial begin
    bus.i_valid = 0; bus.i_a = 0; bus.i_b = 0; bus.i_op = 0;
    bus.i_acc_clr = 0; bus.i_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("init_ready", bus.o_ready, 1);
    chk("init_zero", bus.o_zero, 1);
    @(negedge clk);
    #1 rst_n = 1'b1;

    run_op(0, 9, 8, 0, 0, 0, 4'h1, 1, 1);
    run_op(1, 3, 5, 0, 0, 0, 4'hE, 0, 1);
    run_op(1, 5, 5, 0, 0, 0, 4'h0, 1, 1);
    run_op(4, 5, 3, 0, 0, 0, 4'hF, 0, N + 1);
    run_op(4, 7, 6, 0, 0, 0, 4'hA, 1, N + 1);
    run_op(2, 12, 10, 0, 0, 0, 4'h8, 0, 1);
    run_op(3, 12, 10, 0, 0, 0, 4'hE, 0, 1);
    run_op(6, 7, 7, 0, 0, 0, 4'h0, 0, 1);
    run_op(0, 2, 2, 3, 1, 0, 4'h4, 0, 1);
    chk("bp_acc", bus.o_acc, 4);

    bus.i_acc_clr = 1'b1;
    @(negedge clk);
    bus.i_acc_clr = 1'b0;
    chk("acc_cleared", bus.o_acc, 0);
    run_op(5, 6, 0, 0, 0, 0, 4'h6, 0, 1);
    run_op(5, 7, 0, 0, 0, 0, 4'hD, 0, 1);
    run_op(5, 5, 0, 0, 0, 0, 4'h2, 1, 1);
    chk("acc_sum", bus.o_acc, 2);
    run_op(0, 1, 1, 0, 0, 1, 4'h2, 0, 1);
    chk("acc_clr_wins", bus.o_acc, 0);
    run_op(0, 3, 0, 0, 0, 0, 4'h3, 0, 1);
    chk("acc_pre_rst", bus.o_acc, 3);

    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_op = 3'd4; bus.i_a = 4'd7; bus.i_b = 4'd6;
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", bus.o_busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_valid", bus.o_valid, 0);
    chk("abort_busy", bus.o_busy, 0);
    chk("abort_ready", bus.o_ready, 1);
    chk("abort_acc", bus.o_acc, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(0, 1, 1, 0, 0, 0, 4'h2, 0, 1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
